pipe_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the stall and flush enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also generates the EX-stage operand forwarding selects and supervises the data-memory handshake with a timeout watchdog. A saturating stall-cycle counter is kept for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline,
// with a data-memory timeout watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regs_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regs_write,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic [15:0] wait_cnt;
    logic load_use, mem_wait, hold, lu_act;
    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    assign mem_wait = dmem_req && !dmem_ready;
    // A pending branch stays in EX during a wait and wins once the wait ends.
    assign hold = state == HALT || mem_wait;
    assign lu_act = !hold && !ex_branch_taken && load_use;
    always_comb begin
        pc_stall     = hold || lu_act;
        if_id_stall  = hold || lu_act;
        id_ex_stall  = hold;
        ex_mem_stall = hold;
        mem_wb_flush = hold;
        pc_redirect  = !hold && ex_branch_taken;
        if_id_flush  = !hold && ex_branch_taken;
        id_ex_flush  = (!hold && ex_branch_taken) || lu_act;
        fwd_a_sel    = (mem_regs_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b01 :
                       (wb_regs_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
        fwd_b_sel    = (mem_regs_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b01 :
                       (wb_regs_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (cnt_clr)
                stall_cycles <= '0;
            else if (pc_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (state == HALT) begin
                wait_cnt <= '0;
                if (err_clr) begin
                    state   <= RUN;
                    mem_err <= 1'b0;
                end
            end else if (mem_wait) begin
                if (wait_cnt == 16'(MEM_TIMEOUT - 1)) begin
                    state    <= HALT;
                    mem_err  <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule
